client_rq_ack_q: RTL and testbench

Parametrised next-generation bus-referee client with req/ack handshake. Buffers up to QUEUE_DEPTH request words from local logic and issues them one at a time on the referee req/ack interface. Returns each ack payload to local logic, with per-request timeout, bounded retry and error reporting. Drops in wherever a client0/client1-style port of the referee is used.

---
 rtl/client_rq_ack_q.sv | 224 ++++++++++++++++++++++
 tb/tb_client_rq_ack_q.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/client_rq_ack_q.sv
// ============================================================================
// Module   : client_rq_ack_q
// Purpose  : Queued bus-referee client. Buffers request words and issues them
//            one at a time on a req/ack handshake with timeout and bounded retry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module client_rq_ack_q #(
    parameter int REQ_DATA_WIDTH = 8,
    parameter int ACK_DATA_WIDTH = 8,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 3,
    parameter int BACKOFF_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_valid,
    input  logic [REQ_DATA_WIDTH-1:0]        push_data,
    output logic                             push_ready,
    output logic                             client_req,
    output logic [REQ_DATA_WIDTH-1:0]        client_data_req,
    input  logic                             client_ack,
    input  logic [ACK_DATA_WIDTH-1:0]        client_data_ack,
    output logic                             rsp_valid,
    output logic [ACK_DATA_WIDTH-1:0]        rsp_data,
    output logic                             rsp_error,
    output logic                             busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

    localparam int c_ptr_w   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int c_cnt_w   = $clog2(QUEUE_DEPTH + 1);
    localparam int c_timer_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_retry_w = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int c_bo_w    = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GAP     = 2'd2,
        ST_BACKOFF = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [REQ_DATA_WIDTH-1:0] mem_q [QUEUE_DEPTH];

    state_t                    state_q,      state_d;
    logic [c_ptr_w-1:0]        wr_ptr_q,     wr_ptr_d;
    logic [c_ptr_w-1:0]        rd_ptr_q,     rd_ptr_d;
    logic [c_cnt_w-1:0]        count_q,      count_d;
    logic                      push_ready_q, push_ready_d;
    logic [c_timer_w-1:0]      timer_q,      timer_d;
    logic [c_retry_w-1:0]      retry_q,      retry_d;
    logic [c_bo_w-1:0]         bo_q,         bo_d;
    logic                      req_q,        req_d;
    logic [REQ_DATA_WIDTH-1:0] data_req_q,   data_req_d;
    logic                      rsp_valid_q,  rsp_valid_d;
    logic [ACK_DATA_WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic                      rsp_error_q,  rsp_error_d;
    logic                      busy_q,       busy_d;

    logic                      push_acc;
    logic                      pop;
    logic [REQ_DATA_WIDTH-1:0] head;

    // push_ready is a registered !full, so a pop cannot free a slot for a
    // push on the same edge.
    assign push_acc = push_valid & push_ready_q;
    assign head     = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Handshake FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        bo_d        = bo_q;
        req_d       = req_q;
        pop         = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    timer_d = '0;
                    retry_d = '0;
                end
            end

            ST_REQ: begin
                if (client_ack) begin
                    // An ack on the timeout edge still counts as success.
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = client_data_ack;
                    rsp_error_d = 1'b0;
                    pop         = 1'b1;
                    req_d       = 1'b0;
                    state_d     = ST_GAP;
                end else if (timer_q == c_timer_w'(TIMEOUT_CYCLES - 1)) begin
                    req_d = 1'b0;
                    if (retry_q == c_retry_w'(MAX_RETRIES)) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                        pop         = 1'b1;
                        state_d     = ST_GAP;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        bo_d    = '0;
                        state_d = ST_BACKOFF;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (count_q != '0) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BACKOFF: begin
                if (bo_q == c_bo_w'(BACKOFF_CYCLES - 1)) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    timer_d = '0;
                end else begin
                    bo_d = bo_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // The head only advances on completion, so it is stable while req is high.
        data_req_d = req_d ? head : '0;
        busy_d     = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop      ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        push_ready_d = (count_d != c_cnt_w'(QUEUE_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            push_ready_q <= 1'b1;
            timer_q      <= '0;
            retry_q      <= '0;
            bo_q         <= '0;
            req_q        <= 1'b0;
            data_req_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            push_ready_q <= push_ready_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            bo_q         <= bo_d;
            req_q        <= req_d;
            data_req_q   <= data_req_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            busy_q       <= busy_d;
        end
    end

    assign push_ready      = push_ready_q;
    assign client_req      = req_q;
    assign client_data_req = data_req_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_error       = rsp_error_q;
    assign busy            = busy_q;
    assign queue_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_client_rq_ack_q.sv
// ============================================================================
// Module   : tb_client_rq_ack_q
// Purpose  : Directed, table-driven bench for client_rq_ack_q (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_client_rq_ack_q;

    logic       clk;
    logic       rst;
    logic       push_valid;
    logic [7:0] push_data;
    logic       push_ready;
    logic       client_req;
    logic [7:0] client_data_req;
    logic       client_ack;
    logic [7:0] client_data_ack;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_error;
    logic       busy;
    logic [2:0] queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    client_rq_ack_q #(
        .REQ_DATA_WIDTH (8),
        .ACK_DATA_WIDTH (8),
        .QUEUE_DEPTH    (4),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRIES    (3),
        .BACKOFF_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .push_valid      (push_valid),
        .push_data       (push_data),
        .push_ready      (push_ready),
        .client_req      (client_req),
        .client_data_req (client_data_req),
        .client_ack      (client_ack),
        .client_data_ack (client_data_ack),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error),
        .busy            (busy),
        .queue_count     (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [7:0] pd;
        logic       ack;
        logic [7:0] ad;
        logic       e_req;
        logic [7:0] e_dreq;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       e_re;
        logic       e_busy;
        logic [2:0] e_cnt;
        logic       e_pr;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [7:0] e_dreq,
                              input logic e_rv, input logic [7:0] e_rd, input logic e_re,
                              input logic e_busy, input logic [2:0] e_cnt, input logic e_pr);
        chk({tag, ".client_req"},      32'(client_req),      32'(e_req));
        chk({tag, ".client_data_req"}, 32'(client_data_req), 32'(e_dreq));
        chk({tag, ".rsp_valid"},       32'(rsp_valid),       32'(e_rv));
        chk({tag, ".rsp_data"},        32'(rsp_data),        32'(e_rd));
        chk({tag, ".rsp_error"},       32'(rsp_error),       32'(e_re));
        chk({tag, ".busy"},            32'(busy),            32'(e_busy));
        chk({tag, ".queue_count"},     32'(queue_count),     32'(e_cnt));
        chk({tag, ".push_ready"},      32'(push_ready),      32'(e_pr));
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic step(input logic pv, input logic [7:0] pd, input logic ack,
                        input logic [7:0] ad, input logic r);
        push_valid      = pv;
        push_data       = pd;
        client_ack      = ack;
        client_data_ack = ad;
        rst             = r;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_rd;
    logic       exp_re;

    initial begin
        push_valid      = 1'b0;
        push_data       = 8'h00;
        client_ack      = 1'b0;
        client_data_ack = 8'h00;
        rst             = 1'b1;

        //         rst pv  pd     ack ad     req dreq   rv rd     re busy cnt   pr
        vecs[0]  = '{1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 3'd0, 1};
        vecs[1]  = '{0, 1, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 3'd1, 1};
        vecs[2]  = '{0, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 1, 3'd1, 1};
        vecs[3]  = '{0, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 1, 3'd1, 1};
        vecs[4]  = '{0, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 1, 3'd1, 1};
        vecs[5]  = '{0, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 1, 8'h3C, 0, 1, 3'd0, 1};
        vecs[6]  = '{0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 0, 3'd0, 1};
        vecs[7]  = '{0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 0, 3'd0, 1};
        // fill the queue while the first entry is in flight, then ack forever
        vecs[8]  = '{0, 1, 8'h01, 0, 8'h00, 0, 8'h00, 0, 8'h3C, 0, 0, 3'd1, 1};
        vecs[9]  = '{0, 1, 8'h02, 0, 8'h00, 1, 8'h01, 0, 8'h3C, 0, 1, 3'd2, 1};
        vecs[10] = '{0, 1, 8'h03, 0, 8'h00, 1, 8'h01, 0, 8'h3C, 0, 1, 3'd3, 1};
        vecs[11] = '{0, 1, 8'h04, 0, 8'h00, 1, 8'h01, 0, 8'h3C, 0, 1, 3'd4, 0};
        vecs[12] = '{0, 1, 8'h05, 1, 8'h81, 0, 8'h00, 1, 8'h81, 0, 1, 3'd3, 1};
        vecs[13] = '{0, 0, 8'h00, 1, 8'h82, 1, 8'h02, 0, 8'h81, 0, 1, 3'd3, 1};
        vecs[14] = '{0, 0, 8'h00, 1, 8'h82, 0, 8'h00, 1, 8'h82, 0, 1, 3'd2, 1};
        vecs[15] = '{0, 0, 8'h00, 1, 8'h83, 1, 8'h03, 0, 8'h82, 0, 1, 3'd2, 1};
        vecs[16] = '{0, 0, 8'h00, 1, 8'h83, 0, 8'h00, 1, 8'h83, 0, 1, 3'd1, 1};
        vecs[17] = '{0, 0, 8'h00, 1, 8'h84, 1, 8'h04, 0, 8'h83, 0, 1, 3'd1, 1};
        vecs[18] = '{0, 0, 8'h00, 1, 8'h84, 0, 8'h00, 1, 8'h84, 0, 1, 3'd0, 1};
        vecs[19] = '{0, 0, 8'h00, 1, 8'h84, 0, 8'h00, 0, 8'h84, 0, 0, 3'd0, 1};
        vecs[20] = '{0, 0, 8'h00, 1, 8'h84, 0, 8'h00, 0, 8'h84, 0, 0, 3'd0, 1};
        vecs[21] = '{0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h84, 0, 0, 3'd0, 1};

        step(0, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].pv, vecs[i].pd, vecs[i].ack, vecs[i].ad, vecs[i].rst);
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_dreq, vecs[i].e_rv,
                       vecs[i].e_rd, vecs[i].e_re, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_pr);
        end

        // ---- never acked: 4 attempts of 16 high cycles, 2-cycle backoffs, then error
        exp_rd = 8'h84;
        exp_re = 1'b0;
        step(1, 8'h55, 0, 8'h00, 0);
        check_outs("to.push", 0, 8'h00, 0, exp_rd, exp_re, 0, 3'd1, 1);
        for (int a = 0; a < 4; a++) begin
            step(0, 8'h00, 0, 8'h00, 0);
            check_outs($sformatf("to.a%0d.rise", a), 1, 8'h55, 0, exp_rd, exp_re, 1, 3'd1, 1);
            for (int c = 1; c < 16; c++) begin
                step(0, 8'h00, 0, 8'h00, 0);
                check_outs($sformatf("to.a%0d.c%0d", a, c), 1, 8'h55, 0, exp_rd, exp_re, 1, 3'd1, 1);
            end
            step(0, 8'h00, 0, 8'h00, 0);
            if (a < 3) begin
                check_outs($sformatf("to.a%0d.bo0", a), 0, 8'h00, 0, exp_rd, exp_re, 1, 3'd1, 1);
                step(0, 8'h00, 0, 8'h00, 0);
                check_outs($sformatf("to.a%0d.bo1", a), 0, 8'h00, 0, exp_rd, exp_re, 1, 3'd1, 1);
            end else begin
                exp_rd = 8'h00;
                exp_re = 1'b1;
                check_outs("to.err", 0, 8'h00, 1, exp_rd, exp_re, 1, 3'd0, 1);
            end
        end
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("to.idle", 0, 8'h00, 0, 8'h00, 1, 0, 3'd0, 1);

        // ---- one timeout, ignored ack in backoff, ack on cycle 5 of retry
        step(1, 8'h66, 0, 8'h00, 0);
        check_outs("rt.push", 0, 8'h00, 0, 8'h00, 1, 0, 3'd1, 1);
        for (int c = 0; c < 16; c++) begin
            step(0, 8'h00, 0, 8'h00, 0);
            check_outs($sformatf("rt.a0.c%0d", c), 1, 8'h66, 0, 8'h00, 1, 1, 3'd1, 1);
        end
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("rt.bo0", 0, 8'h00, 0, 8'h00, 1, 1, 3'd1, 1);
        step(0, 8'h00, 1, 8'h77, 0);
        check_outs("rt.bo1_ack", 0, 8'h00, 0, 8'h00, 1, 1, 3'd1, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("rt.a1.rise", 1, 8'h66, 0, 8'h00, 1, 1, 3'd1, 1);
        for (int c = 1; c < 5; c++) begin
            step(0, 8'h00, 0, 8'h00, 0);
            check_outs($sformatf("rt.a1.c%0d", c), 1, 8'h66, 0, 8'h00, 1, 1, 3'd1, 1);
        end
        step(0, 8'h00, 1, 8'h99, 0);
        check_outs("rt.ack", 0, 8'h00, 1, 8'h99, 0, 1, 3'd0, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("rt.idle", 0, 8'h00, 0, 8'h99, 0, 0, 3'd0, 1);

        // ---- ack on exactly the 16th high cycle wins over the timeout
        step(1, 8'h77, 0, 8'h00, 0);
        check_outs("edge.push", 0, 8'h00, 0, 8'h99, 0, 0, 3'd1, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("edge.rise", 1, 8'h77, 0, 8'h99, 0, 1, 3'd1, 1);
        for (int c = 1; c < 16; c++) begin
            step(0, 8'h00, 0, 8'h00, 0);
            check_outs($sformatf("edge.c%0d", c), 1, 8'h77, 0, 8'h99, 0, 1, 3'd1, 1);
        end
        step(0, 8'h00, 1, 8'h42, 0);
        check_outs("edge.ack", 0, 8'h00, 1, 8'h42, 0, 1, 3'd0, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("edge.gap", 0, 8'h00, 0, 8'h42, 0, 0, 3'd0, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("edge.idle", 0, 8'h00, 0, 8'h42, 0, 0, 3'd0, 1);

        // ---- reset while a request is in flight with 2 entries queued
        step(1, 8'h11, 0, 8'h00, 0);
        check_outs("rs.push0", 0, 8'h00, 0, 8'h42, 0, 0, 3'd1, 1);
        step(1, 8'h22, 0, 8'h00, 0);
        check_outs("rs.push1", 1, 8'h11, 0, 8'h42, 0, 1, 3'd2, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("rs.hold", 1, 8'h11, 0, 8'h42, 0, 1, 3'd2, 1);
        step(0, 8'h00, 1, 8'h5A, 1);
        check_outs("rs.rst", 0, 8'h00, 0, 8'h00, 0, 0, 3'd0, 1);
        step(0, 8'h00, 1, 8'h5A, 0);
        check_outs("rs.idle_ack0", 0, 8'h00, 0, 8'h00, 0, 0, 3'd0, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("rs.idle", 0, 8'h00, 0, 8'h00, 0, 0, 3'd0, 1);
        step(0, 8'h00, 1, 8'hA0, 0);
        check_outs("rs.idle_ack1", 0, 8'h00, 0, 8'h00, 0, 0, 3'd0, 1);

        // ---- still functional after reset: immediate ack
        step(1, 8'h33, 0, 8'h00, 0);
        check_outs("post.push", 0, 8'h00, 0, 8'h00, 0, 0, 3'd1, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("post.rise", 1, 8'h33, 0, 8'h00, 0, 1, 3'd1, 1);
        step(0, 8'h00, 1, 8'hC3, 0);
        check_outs("post.ack", 0, 8'h00, 1, 8'hC3, 0, 1, 3'd0, 1);
        step(0, 8'h00, 0, 8'h00, 0);
        check_outs("post.idle", 0, 8'h00, 0, 8'hC3, 0, 0, 3'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
